// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer (and the stopwatch next to it).
// Contents:
//   MIN_W / SEC_W : widths of the minutes / seconds display fields
//   SEC_MAX       : largest legal seconds value
//   status_e      : 2-bit status code, also used directly as the FSM state
//   sat_sec()     : clamps a raw seconds value to SEC_MAX
package countdown_pkg;

   localparam int MIN_W = 8;
   localparam int SEC_W = 6;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10,
      ST_EXPIRED = 2'b11
   } status_e;

   function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] s);
      return (s > SEC_MAX) ? SEC_MAX : s;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command / display bundle of the countdown timer.
// master : drives load/load_min/load_sec/start/stop/clear, reads display outputs
// slave  : the timer; reads commands, drives minutes/seconds/status/done
// Handshake: there is no valid/ready pair. Every command bit is a level that
// the timer samples on each rising clock edge and treats as a one-cycle
// command; outputs are registered and change only right after an edge.
interface countdown_timer_if;
   import countdown_pkg::*;

   logic             load;
   logic [MIN_W-1:0] load_min;
   logic [SEC_W-1:0] load_sec;
   logic             start;
   logic             stop;
   logic             clear;
   logic [MIN_W-1:0] minutes;
   logic [SEC_W-1:0] seconds;
   logic [1:0]       status;
   logic             done;

   modport master (
      output load, load_min, load_sec, start, stop, clear,
      input  minutes, seconds, status, done
   );

   modport slave (
      input  load, load_min, load_sec, start, stop, clear,
      output minutes, seconds, status, done
   );

endinterface

// File: rtl/countdown_timer_prescaler.sv
// tick_prescaler: divides clk down to a one-second tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, counter to 0
//   clr  : synchronous clear, counter to 0 (wins over en)
//   en   : count enable; counter holds its value while low
//   tick : one-cycle pulse in the cycle the counter sits at TICKS_PER_SEC-1
//          with en high; the counter wraps to 0 on that edge
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: minutes/seconds countdown with preset, pause and expiry.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset (preset, count, state, prescaler)
//   bus : countdown_timer_if.slave
//         commands  load(load_min, load_sec), start, stop, clear
//         display   minutes, seconds, status (= FSM state), done pulse
// Command priority within one cycle: clear > stop > start > load. The highest
// asserted command decides the action even when that command is then ignored
// by the current state, so e.g. stop+start from IDLE does nothing.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100000000
) (
   input logic              clk,
   input logic              rst,
   countdown_timer_if.slave bus
);

   status_e          state_q, state_d;
   logic [MIN_W-1:0] pre_min_q, pre_min_d;
   logic [SEC_W-1:0] pre_sec_q, pre_sec_d;
   logic [MIN_W-1:0] cnt_min_q, cnt_min_d;
   logic [SEC_W-1:0] cnt_sec_q, cnt_sec_d;
   logic             done_q, done_d;

   logic presc_clr;
   logic presc_en;
   logic tick;
   logic count_zero;

   // The prescaler runs for every cycle spent in RUNNING, including the cycle
   // in which stop is taken, so a pause keeps the partial second accumulated
   // so far and a resume finishes it.
   assign presc_en   = (state_q == ST_RUNNING);
   assign count_zero = (cnt_min_q == '0) && (cnt_sec_q == '0);

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .clr (presc_clr),
      .en  (presc_en),
      .tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      pre_min_d = pre_min_q;
      pre_sec_d = pre_sec_q;
      cnt_min_d = cnt_min_q;
      cnt_sec_d = cnt_sec_q;
      done_d    = 1'b0;
      presc_clr = 1'b0;

      if (bus.clear) begin
         cnt_min_d = pre_min_q;
         cnt_sec_d = pre_sec_q;
         state_d   = ST_IDLE;
         presc_clr = 1'b1;
      end else if (bus.stop) begin
         // A coincident tick is dropped: the count freezes as it is.
         if (state_q == ST_RUNNING) begin
            state_d = ST_PAUSED;
         end
      end else begin
         if (bus.start) begin
            if ((state_q == ST_IDLE || state_q == ST_PAUSED) && !count_zero) begin
               state_d   = ST_RUNNING;
               // Fresh start gets a full first second; resume keeps the phase.
               presc_clr = (state_q == ST_IDLE);
            end
         end else if (bus.load) begin
            if (state_q != ST_RUNNING) begin
               pre_min_d = bus.load_min;
               pre_sec_d = sat_sec(bus.load_sec);
               cnt_min_d = bus.load_min;
               cnt_sec_d = sat_sec(bus.load_sec);
               state_d   = ST_IDLE;
            end
         end

         // start/load never act in RUNNING, so they cannot collide with this.
         if (state_q == ST_RUNNING && tick) begin
            if (cnt_sec_q != '0) begin
               cnt_sec_d = cnt_sec_q - 1'b1;
               if (cnt_min_q == '0 && cnt_sec_q == 6'd1) begin
                  state_d = ST_EXPIRED;
                  done_d  = 1'b1;
               end
            end else if (cnt_min_q != '0) begin
               cnt_min_d = cnt_min_q - 1'b1;
               cnt_sec_d = SEC_MAX;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_min_q <= '0;
         pre_sec_q <= '0;
         cnt_min_q <= '0;
         cnt_sec_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_min_q <= pre_min_d;
         pre_sec_q <= pre_sec_d;
         cnt_min_q <= cnt_min_d;
         cnt_sec_q <= cnt_sec_d;
         done_q    <= done_d;
      end
   end

   assign bus.minutes = cnt_min_q;
   assign bus.seconds = cnt_sec_q;
   assign bus.status  = state_q;
   assign bus.done    = done_q;

endmodule
